fround: RTL and testbench

FROUND -- requirements
Module: fround

---
 rtl/fround.sv | 223 ++++++++++++++++++++++
 tb/tb_fround.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fround.sv
// Rounds a cast-stage {sign, exp, frac, grs} into an IEEE 754 single with a fixed 4-edge latency.
// Optional macro FROUND_RMM_EN enables round-to-nearest-max-magnitude (rm=100).
module fround #(
    parameter int unsigned OPERAND_WIDTH  = 32,
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned FRACTION_WIDTH = 23
) (
    input  logic                      fpu_clk,
    input  logic                      fpu_rst_n,
    input  logic                      fround_en_i,
    input  logic [2:0]                fround_rm_i,
    input  logic                      fround_sign_i,
    input  logic [EXPONENT_WIDTH-1:0] fround_exp_i,
    input  logic [FRACTION_WIDTH-1:0] fround_frac_i,
    input  logic [2:0]                fround_grs_bit_i,
    input  logic                      fround_overflow_i,
    output logic [OPERAND_WIDTH-1:0]  fround_result_o,
    output logic                      fround_inexact_o,
    output logic                      fround_overflow_o,
    output logic                      fround_invalid_rm_o,
    output logic                      fround_ready_o
);

    localparam int unsigned EW  = EXPONENT_WIDTH;
    localparam int unsigned EW1 = EXPONENT_WIDTH + 1;
    localparam int unsigned FW  = FRACTION_WIDTH;
    localparam int unsigned SW  = FRACTION_WIDTH + 1;

`ifdef FROUND_RMM_EN
    localparam bit RMM_EN = 1'b1;
`else
    localparam bit RMM_EN = 1'b0;
`endif

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [EW-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0] EXP_MAXF = {EXP_ONES[EW-1:1], 1'b0};

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        ROUND,
        NORM,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic [EW-1:0]            exp_q, exp_d;
    logic [FW-1:0]            frac_q, frac_d;
    logic [2:0]               grs_q, grs_d;
    logic                     ovf_in_q, ovf_in_d;
    logic [2:0]               rm_q, rm_d;
    logic [SW-1:0]            sum_q, sum_d;
    logic                     norm_ovf_q, norm_ovf_d;
    logic [OPERAND_WIDTH-1:0] result_q, result_d;
    logic                     inexact_q, inexact_d;
    logic                     overflow_q, overflow_d;
    logic                     invalid_q, invalid_d;
    logic                     ready_q, ready_d;

    logic inc_c;
    logic rm_ok_c;
    logic to_inf_c;
    logic ovf_c;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fround_en_i) state_d = CAPTURE;
            CAPTURE: state_d = fround_en_i ? ROUND : IDLE;
            ROUND:   state_d = fround_en_i ? NORM  : IDLE;
            NORM:    state_d = fround_en_i ? DONE  : IDLE;
            DONE:    state_d = fround_en_i ? DONE  : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Rounding mode decode on the captured operands
    always_comb begin
        inc_c    = 1'b0;
        to_inf_c = 1'b0;
        rm_ok_c  = (rm_q < RM_RMM) || ((rm_q == RM_RMM) && RMM_EN);
        case (rm_q)
            RM_RNE: begin
                inc_c    = grs_q[2] & (grs_q[1] | grs_q[0] | frac_q[0]);
                to_inf_c = 1'b1;
            end
            RM_RTZ: begin
                inc_c    = 1'b0;
                to_inf_c = 1'b0;
            end
            RM_RDN: begin
                inc_c    = sign_q & (|grs_q);
                to_inf_c = sign_q;
            end
            RM_RUP: begin
                inc_c    = ~sign_q & (|grs_q);
                to_inf_c = ~sign_q;
            end
            RM_RMM: begin
                inc_c    = grs_q[2] & RMM_EN;
                to_inf_c = 1'b1;
            end
            default: begin
                inc_c    = 1'b0;
                to_inf_c = 1'b0;
            end
        endcase
        ovf_c = ovf_in_q | norm_ovf_q;
    end

    // Datapath: capture, add increment, normalise carry, publish result
    always_comb begin
        sign_d     = sign_q;
        exp_d      = exp_q;
        frac_d     = frac_q;
        grs_d      = grs_q;
        ovf_in_d   = ovf_in_q;
        rm_d       = rm_q;
        sum_d      = sum_q;
        norm_ovf_d = norm_ovf_q;
        result_d   = result_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;
        ready_d    = (state_q == DONE) && fround_en_i;

        case (state_q)
            CAPTURE: begin
                sign_d     = fround_sign_i;
                exp_d      = fround_exp_i;
                frac_d     = fround_frac_i;
                grs_d      = fround_grs_bit_i;
                ovf_in_d   = fround_overflow_i;
                rm_d       = fround_rm_i;
                norm_ovf_d = 1'b0;
            end
            ROUND: begin
                sum_d = {1'b0, frac_q} + SW'(inc_c);
            end
            NORM: begin
                if (sum_q[FW]) begin
                    frac_d = '0;
                    exp_d  = exp_q + EW'(1);
                end else begin
                    frac_d = sum_q[FW-1:0];
                end
                // Computed one bit wider so an all-ones input exponent cannot wrap
                norm_ovf_d = (EW1'(exp_q) + EW1'(sum_q[FW])) >= EW1'(EXP_ONES);
            end
            DONE: begin
                if (fround_en_i && !ready_q) begin
                    if (!rm_ok_c) begin
                        result_d   = OPERAND_WIDTH'({1'b0, EXP_ONES, 1'b1, {(FW-1){1'b0}}});
                        inexact_d  = 1'b0;
                        overflow_d = 1'b0;
                        invalid_d  = 1'b1;
                    end else if (ovf_c) begin
                        result_d   = to_inf_c ? OPERAND_WIDTH'({sign_q, EXP_ONES, {FW{1'b0}}})
                                              : OPERAND_WIDTH'({sign_q, EXP_MAXF, {FW{1'b1}}});
                        inexact_d  = 1'b1;
                        overflow_d = 1'b1;
                        invalid_d  = 1'b0;
                    end else begin
                        result_d   = OPERAND_WIDTH'({sign_q, exp_q, frac_q});
                        inexact_d  = |grs_q;
                        overflow_d = 1'b0;
                        invalid_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            frac_q     <= '0;
            grs_q      <= '0;
            ovf_in_q   <= 1'b0;
            rm_q       <= '0;
            sum_q      <= '0;
            norm_ovf_q <= 1'b0;
            result_q   <= '0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            frac_q     <= frac_d;
            grs_q      <= grs_d;
            ovf_in_q   <= ovf_in_d;
            rm_q       <= rm_d;
            sum_q      <= sum_d;
            norm_ovf_q <= norm_ovf_d;
            result_q   <= result_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
            ready_q    <= ready_d;
        end
    end

    assign fround_result_o     = result_q;
    assign fround_inexact_o    = inexact_q;
    assign fround_overflow_o   = overflow_q;
    assign fround_invalid_rm_o = invalid_q;
    assign fround_ready_o      = ready_q;

endmodule

// File: tb/tb_fround.sv
// Self-checking bench for fround: directed vector table, abort/reset sequences, random vs. reference model.
module tb_fround;

`ifdef FROUND_RMM_EN
    localparam bit RMM_EN = 1'b1;
`else
    localparam bit RMM_EN = 1'b0;
`endif

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic [2:0]  grs;
        logic        ovf;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        inx;
        logic        ovfo;
        logic        inv;
    } vec_t;

    logic        fpu_clk = 1'b0;
    logic        fpu_rst_n;
    logic        en;
    logic [2:0]  rm;
    logic        sign;
    logic [7:0]  exp_in;
    logic [22:0] frac;
    logic [2:0]  grs;
    logic        ovf_in;
    logic [31:0] result;
    logic        inexact, overflow, invalid_rm, ready;

    int checks = 0;
    int errors = 0;

    fround dut (
        .fpu_clk            (fpu_clk),
        .fpu_rst_n          (fpu_rst_n),
        .fround_en_i        (en),
        .fround_rm_i        (rm),
        .fround_sign_i      (sign),
        .fround_exp_i       (exp_in),
        .fround_frac_i      (frac),
        .fround_grs_bit_i   (grs),
        .fround_overflow_i  (ovf_in),
        .fround_result_o    (result),
        .fround_inexact_o   (inexact),
        .fround_overflow_o  (overflow),
        .fround_invalid_rm_o(invalid_rm),
        .fround_ready_o     (ready)
    );

    always #5 fpu_clk = ~fpu_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, want);
        end
    endtask

    // Reference: value-level rounding of an integer significand with a G/R/S remainder
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int unsigned m, e;
        bit          ok, nz, above, tie, up, ovf, toinf;
        r  = v;
        ok = (v.rm < 3'd4) || ((v.rm == 3'd4) && RMM_EN);
        if (!ok) begin
            r.res = 32'h7FC00000; r.inx = 1'b0; r.ovfo = 1'b0; r.inv = 1'b1;
            return r;
        end
        m     = int'(v.frac);
        e     = int'(v.exp);
        nz    = (v.grs != 3'd0);
        above = v.grs > 3'b100;
        tie   = v.grs == 3'b100;
        case (v.rm)
            3'd0:    up = above || (tie && (m % 2 == 1));
            3'd2:    up = v.sign && nz;
            3'd3:    up = !v.sign && nz;
            3'd4:    up = v.grs >= 3'b100;
            default: up = 1'b0;
        endcase
        m = m + (up ? 1 : 0);
        if (m == (1 << 23)) begin
            m = 0;
            e = e + 1;
        end
        ovf   = v.ovf || (e >= 255);
        toinf = (v.rm == 3'd0) || (v.rm == 3'd4) || (v.rm == 3'd2 && v.sign) || (v.rm == 3'd3 && !v.sign);
        r.inv  = 1'b0;
        r.ovfo = ovf;
        r.inx  = nz || ovf;
        if (ovf) r.res = toinf ? {v.sign, 31'h7F800000} : {v.sign, 31'h7F7FFFFF};
        else     r.res = {v.sign, 8'(e), 23'(m)};
        return r;
    endfunction

    task automatic drive(input vec_t v);
        sign = v.sign; exp_in = v.exp; frac = v.frac; grs = v.grs; ovf_in = v.ovf; rm = v.rm;
    endtask

    task automatic scramble();
        sign = ~sign; exp_in = 8'($urandom); frac = 23'($urandom);
        grs = 3'($urandom); ovf_in = 1'($urandom); rm = 3'($urandom);
    endtask

    // One full operation: en at edge N, check ready only after edge N+4, then release
    task automatic run_op(input vec_t v, input string name);
        @(negedge fpu_clk);
        drive(v);
        en = 1'b1;
        @(posedge fpu_clk);
        @(posedge fpu_clk); #1;
        scramble();
        @(posedge fpu_clk);
        @(posedge fpu_clk); #1;
        chk({name, ".early_ready"}, 32'(ready), 32'd0);
        @(posedge fpu_clk); #1;
        chk({name, ".ready"},    32'(ready),      32'd1);
        chk({name, ".result"},   result,          v.res);
        chk({name, ".inexact"},  32'(inexact),    32'(v.inx));
        chk({name, ".overflow"}, 32'(overflow),   32'(v.ovfo));
        chk({name, ".invalid"},  32'(invalid_rm), 32'(v.inv));
        en = 1'b0;
        @(posedge fpu_clk); #1;
        chk({name, ".ready_drop"}, 32'(ready), 32'd0);
        chk({name, ".hold"},       result,     v.res);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v      = '0;
        v.sign = 1'($urandom);
        v.exp  = 8'($urandom_range(0, 254));
        v.frac = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        v.grs  = 3'($urandom);
        v.ovf  = ($urandom_range(0, 15) == 0);
        v.rm   = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) begin
            v.exp = 8'd0; v.frac = 23'd0; v.grs = 3'd0;
        end
        return v;
    endfunction

    vec_t tbl [14];
    vec_t v;
    logic [31:0] prev;

    initial begin
        tbl[0]  = '{1'b0, 8'h96, 23'h000001, 3'b100, 1'b0, 3'b000, 32'h4B000002, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h96, 23'h000002, 3'b100, 1'b0, 3'b000, 32'h4B000002, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h96, 23'h000002, 3'b100, 1'b0, 3'b011, 32'h4B000003, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h9D, 23'h7FFFFF, 3'b110, 1'b0, 3'b000, 32'h4F000000, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 1'b0, 3'b000, 32'h7F800000, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'h80, 23'h000000, 3'b000, 1'b1, 3'b001, 32'hFF7FFFFF, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h96, 23'h000001, 3'b111, 1'b0, 3'b101, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h80, 23'h000000, 3'b000, 1'b1, 3'b110, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
`ifdef FROUND_RMM_EN
        tbl[8]  = '{1'b0, 8'h96, 23'h000001, 3'b100, 1'b0, 3'b100, 32'h4B000002, 1'b1, 1'b0, 1'b0};
`else
        tbl[8]  = '{1'b0, 8'h96, 23'h000001, 3'b100, 1'b0, 3'b100, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
`endif
        tbl[9]  = '{1'b1, 8'h00, 23'h000000, 3'b000, 1'b0, 3'b000, 32'h80000000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b001, 1'b0, 3'b010, 32'hFF800000, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'h80, 23'h000000, 3'b000, 1'b1, 3'b011, 32'h7F800000, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'h80, 23'h000000, 3'b000, 1'b1, 3'b010, 32'h7F7FFFFF, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'h96, 23'h000001, 3'b111, 1'b0, 3'b001, 32'h4B000001, 1'b1, 1'b0, 1'b0};

        en = 1'b0; sign = 1'b0; exp_in = '0; frac = '0; grs = '0; ovf_in = 1'b0; rm = '0;
        fpu_rst_n = 1'b1;
        #2 fpu_rst_n = 1'b0;
        #1;
        chk("reset.result",   result,           32'd0);
        chk("reset.flags",    32'({inexact, overflow, invalid_rm}), 32'd0);
        chk("reset.ready",    32'(ready),       32'd0);
        repeat (3) @(negedge fpu_clk);
        fpu_rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Abort right after CAPTURE: no ready, outputs unchanged, FSM usable again
        prev = result;
        @(negedge fpu_clk);
        drive(tbl[3]);
        en = 1'b1;
        @(posedge fpu_clk);
        @(posedge fpu_clk); #1;
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge fpu_clk); #1;
            chk($sformatf("abort.ready%0d", k), 32'(ready), 32'd0);
        end
        chk("abort.hold", result, prev);
        run_op(tbl[0], "after_abort");

        // Asynchronous reset while in ROUND after a non-zero result
        run_op(tbl[4], "pre_reset");
        @(negedge fpu_clk);
        drive(tbl[1]);
        en = 1'b1;
        @(posedge fpu_clk);
        @(posedge fpu_clk); #2;
        fpu_rst_n = 1'b0;
        #1;
        chk("midrst.result", result,      32'd0);
        chk("midrst.flags",  32'({inexact, overflow, invalid_rm}), 32'd0);
        chk("midrst.ready",  32'(ready),  32'd0);
        en = 1'b0;
        @(negedge fpu_clk);
        fpu_rst_n = 1'b1;
        repeat (6) @(posedge fpu_clk);
        #1;
        chk("postrst.idle_ready",  32'(ready), 32'd0);
        chk("postrst.idle_result", result,     32'd0);
        run_op(tbl[2], "after_reset");

        for (int i = 0; i < 200; i++) begin
            v = model(rand_vec());
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
